// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter.
//   state_t    : sequencer state encoding (IDLE -> ACCESS -> DONE)
//   REQ_*      : requester indices (0 = CPU bus, 1 = DMA/loader)
//   DIR_*, LOAD_*, ASSERT_* : memory strobe levels
//   rr_pick    : two-way round-robin winner selection
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_DMA    = 1'b1;

    localparam logic DIR_WRITE  = 1'b0;
    localparam logic DIR_READ   = 1'b1;
    localparam logic LOAD_OFF   = 1'b0;
    localparam logic LOAD_ON    = 1'b1;
    // assert_main is active-low: ON drives the memory onto the main bus
    localparam logic ASSERT_ON  = 1'b0;
    localparam logic ASSERT_OFF = 1'b1;

    // A lone request always wins; under contention the requester that was
    // not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last);
        logic pick;
        if (req0 && req1)
            pick = ~last;
        else if (req1)
            pick = REQ_DMA;
        else
            pick = REQ_CPU;
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the single-port
// main memory. Each access is IDLE -> ACCESS -> DONE (3 cycles), with a
// one-cycle ack in DONE.
//
// Ports:
//   clk, reset                  : system clock, async active-high reset
//   r0_* / r1_*                 : requester groups (req, we, addr, wdata, ack)
//   rdata                       : last read data, updated only by reads
//   grant                       : requester currently or last served
//   busy                        : high while not IDLE
//   mem_addr/mem_wdata          : memory address and write data
//   mem_bus_dir                 : 0 = write into memory, 1 = read
//   mem_load_main               : active-high write strobe
//   mem_assert_main             : active-low read output enable
//   mem_rdata                   : combinational memory read data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | strobes inactive; sample requests, latch winner's access
// ST_ACCESS | strobes active for one cycle; read data captured at exit
// ST_DONE   | ack to granted requester; requests ignored
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [WIDTH_ADDR-1:0] r0_addr,
    input  logic [WIDTH-1:0]      r0_wdata,
    output logic                  r0_ack,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [WIDTH_ADDR-1:0] r1_addr,
    input  logic [WIDTH-1:0]      r1_wdata,
    output logic                  r1_ack,
    output logic [WIDTH-1:0]      rdata,
    output logic                  grant,
    output logic                  busy,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic                  mem_bus_dir,
    output logic                  mem_load_main,
    output logic                  mem_assert_main,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    state_t                  state;
    logic                    we_q;
    logic                    winner;
    logic                    sel_we;
    logic [WIDTH_ADDR-1:0]   sel_addr;
    logic [WIDTH-1:0]        sel_wdata;

    always_comb begin
        winner    = rr_pick(r0_req, r1_req, grant);
        sel_we    = r0_we;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (winner == REQ_DMA) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    assign busy = (state != ST_IDLE);

    // Strobes are registered and set on entry to ACCESS so they are clean for
    // the whole access cycle. Reset clears mem_load_main asynchronously, which
    // suppresses a write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            we_q            <= 1'b0;
            grant           <= REQ_DMA;
            r0_ack          <= 1'b0;
            r1_ack          <= 1'b0;
            rdata           <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_bus_dir     <= DIR_READ;
            mem_load_main   <= LOAD_OFF;
            mem_assert_main <= ASSERT_OFF;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (r0_req || r1_req) begin
                        grant     <= winner;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        if (sel_we) begin
                            mem_bus_dir     <= DIR_WRITE;
                            mem_load_main   <= LOAD_ON;
                            mem_assert_main <= ASSERT_OFF;
                        end else begin
                            mem_bus_dir     <= DIR_READ;
                            mem_load_main   <= LOAD_OFF;
                            mem_assert_main <= ASSERT_ON;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q)
                        rdata <= mem_rdata;
                    r0_ack          <= (grant == REQ_CPU);
                    r1_ack          <= (grant == REQ_DMA);
                    mem_bus_dir     <= DIR_READ;
                    mem_load_main   <= LOAD_OFF;
                    mem_assert_main <= ASSERT_OFF;
                    state           <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and per-requester
// scoreboard queues; acks are matched against the queued expectations.
module tb_mem_arbiter;

    localparam int WA = 16;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [WA-1:0] r0_addr = '0;
    logic [W-1:0]  r0_wdata = '0;
    logic          r0_ack;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [WA-1:0] r1_addr = '0;
    logic [W-1:0]  r1_wdata = '0;
    logic          r1_ack;
    logic [W-1:0]  rdata;
    logic          grant, busy;
    logic [WA-1:0] mem_addr;
    logic          mem_bus_dir, mem_load_main, mem_assert_main;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    mem_arbiter #(.WIDTH_ADDR(WA), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .mem_bus_dir(mem_bus_dir),
        .mem_load_main(mem_load_main), .mem_assert_main(mem_assert_main),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // single-port memory: synchronous write on load_main, combinational read
    logic [W-1:0] mem [0:65535] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_load_main)
            mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic       we;
        logic [7:0] rd;
        int         exp_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt [2] = '{0, 0};
    int   last_ack_cyc [2] = '{-1, -1};
    int   last_ack_idx = -1;
    int   first_idx = -1;
    bit   gap_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic we, input logic [7:0] rd, input int ec);
        exp_t e;
        e.we = we; e.rd = rd; e.exp_cyc = ec;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic on_ack(input int idx);
        exp_t e;
        int   qs;
        ack_cnt[idx]++;
        qs = (idx == 0) ? q0.size() : q1.size();
        chk("ack_expected", (qs > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("grant_at_ack", 32'(grant), 32'(idx));
        if (qs > 0) begin
            e = (idx == 0) ? q0.pop_front() : q1.pop_front();
            if (e.exp_cyc >= 0)
                chk("ack_latency", 32'(cyc), 32'(e.exp_cyc));
            if (!e.we)
                chk("read_data", 32'(rdata), 32'(e.rd));
        end
        if (gap_mode) begin
            if (first_idx < 0) first_idx = idx;
            if (last_ack_cyc[idx] >= 0)
                chk("ack_gap_le6", 32'(cyc - last_ack_cyc[idx] <= 6), 32'd1);
            if (last_ack_idx >= 0)
                chk("grant_alternates", 32'(idx != last_ack_idx), 32'd1);
        end
        last_ack_cyc[idx] = cyc;
        last_ack_idx = idx;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (r0_ack || r1_ack)
            chk("acks_exclusive", 32'(r0_ack & r1_ack), 32'd0);
        if (r0_ack) on_ack(0);
        if (r1_ack) on_ack(1);
    endtask

    task automatic drive(input int idx, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wd);
        if (idx == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    // Uncontended access starting from IDLE; ends one IDLE cycle after ack.
    task automatic single(input int idx, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] erd);
        int         n0;
        logic [7:0] rd_before;
        n0 = ack_cnt[idx];
        rd_before = rdata;
        chk("idle_load_off", 32'(mem_load_main), 32'd0);
        drive(idx, 1'b1, we, addr, wd);
        push_exp(idx, we, erd, cyc + 2);
        tick();
        chk("access_mem_addr", 32'(mem_addr), 32'(addr));
        chk("access_bus_dir", 32'(mem_bus_dir), 32'(!we));
        chk("access_load", 32'(mem_load_main), 32'(we));
        chk("access_assert", 32'(mem_assert_main), 32'(we));
        chk("access_busy", 32'(busy), 32'd1);
        if (we) chk("access_wdata", 32'(mem_wdata), 32'(wd));
        tick();
        chk("ack_count", 32'(ack_cnt[idx]), 32'(n0 + 1));
        chk("done_load_off", 32'(mem_load_main), 32'd0);
        chk("done_assert_off", 32'(mem_assert_main), 32'd1);
        chk("done_addr_held", 32'(mem_addr), 32'(addr));
        if (we) chk("write_keeps_rdata", 32'(rdata), 32'(rd_before));
        drive(idx, 1'b0, we, addr, wd);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input bit check_vals);
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        reset = 1'b1;
        tick();
        if (check_vals) begin
            chk("rst_grant", 32'(grant), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_acks", 32'({r0_ack, r1_ack}), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_strobes", 32'({mem_bus_dir, mem_load_main, mem_assert_main}), 32'b101);
        end
        q0.delete();
        q1.delete();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int base, n0, nprev0, nprev1;
        int issued [2];
        bit pend [2];

        // 1: reset values, write then read back
        do_reset(1'b1);
        single(0, 1'b1, 16'h1234, 8'hA5, 8'h00);
        single(0, 1'b0, 16'h1234, 8'h00, 8'hA5);

        // 2: simultaneous requests from reset; r0 first, r1 three cycles later
        do_reset(1'b0);
        drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1, 1'b1, 1'b1, 16'h0020, 8'h3C);
        push_exp(0, 1'b0, 8'h00, cyc + 2);
        push_exp(1, 1'b1, 8'h00, cyc + 5);
        n0 = ack_cnt[0] + ack_cnt[1];
        for (int t = 0; t < 20 && (ack_cnt[0] + ack_cnt[1]) < n0 + 2; t++) begin
            nprev0 = ack_cnt[0];
            nprev1 = ack_cnt[1];
            tick();
            if (ack_cnt[0] != nprev0) r0_req = 1'b0;
            if (ack_cnt[1] != nprev1) r1_req = 1'b0;
        end
        chk("pair_acks", 32'(ack_cnt[0] + ack_cnt[1] - n0), 32'd2);
        r0_req = 1'b0; r1_req = 1'b0;
        tick();

        // 3: continuous contention, 6 writes per requester
        gap_mode = 1'b1;
        base = ack_cnt[0] + ack_cnt[1];
        issued = '{1, 1};
        pend = '{1'b0, 1'b0};
        drive(0, 1'b1, 1'b1, 16'h0200, 8'h10);
        drive(1, 1'b1, 1'b1, 16'h0300, 8'h80);
        push_exp(0, 1'b1, 8'h00, -1);
        push_exp(1, 1'b1, 8'h00, -1);
        for (int t = 0; t < 80 && (ack_cnt[0] + ack_cnt[1] - base) < 12; t++) begin
            nprev0 = ack_cnt[0];
            nprev1 = ack_cnt[1];
            tick();
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    pend[i] = 1'b0;
                    if (issued[i] < 6) begin
                        drive(i, 1'b1, 1'b1, 16'(((i == 0) ? 16'h0200 : 16'h0300) + issued[i]),
                              8'(((i == 0) ? 8'h10 : 8'h80) + issued[i]));
                        push_exp(i, 1'b1, 8'h00, -1);
                        issued[i]++;
                    end else begin
                        drive(i, 1'b0, 1'b1, 16'h0, 8'h0);
                    end
                end
            end
            if (ack_cnt[0] != nprev0) pend[0] = 1'b1;
            if (ack_cnt[1] != nprev1) pend[1] = 1'b1;
        end
        chk("contention_total", 32'(ack_cnt[0] + ack_cnt[1] - base), 32'd12);
        chk("contention_first", 32'(first_idx), 32'd0);
        gap_mode = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        tick(); tick(); tick();
        single(0, 1'b0, 16'h0205, 8'h00, 8'h15);
        single(1, 1'b0, 16'h0303, 8'h00, 8'h83);

        // 4: address boundaries
        single(1, 1'b1, 16'hFFFF, 8'hFF, 8'h00);
        single(1, 1'b1, 16'h0000, 8'h01, 8'h00);
        single(1, 1'b0, 16'hFFFF, 8'h00, 8'hFF);
        single(1, 1'b0, 16'h0000, 8'h00, 8'h01);

        // 5: reset mid-ACCESS suppresses the write and the ack
        n0 = ack_cnt[0];
        drive(0, 1'b1, 1'b1, 16'h0040, 8'h77);
        tick();
        chk("abort_load_before", 32'(mem_load_main), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_load_dropped", 32'(mem_load_main), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("abort_no_ack", 32'(ack_cnt[0]), 32'(n0));
        single(0, 1'b0, 16'h0040, 8'h00, 8'h00);

        // 6: req held through DONE is not a second request
        n0 = ack_cnt[0];
        drive(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        push_exp(0, 1'b0, 8'hA5, cyc + 2);
        tick();
        tick();
        chk("held_done_busy", 32'(busy), 32'd1);
        tick();
        chk("held_idle_busy", 32'(busy), 32'd0);
        r0_req = 1'b0;
        tick(); tick(); tick();
        chk("held_single_ack", 32'(ack_cnt[0]), 32'(n0 + 1));
        chk("held_final_busy", 32'(busy), 32'd0);
        chk("held_queue_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port main memory block.
- Requester 0 is the CPU bus interface; requester 1 is the DMA/loader.
- Grants the memory to one requester at a time using round-robin order.
- Drives the memory's address, direction, load and assert strobes for each access, latches read data, and returns a one-cycle ack.

Parameters:
WIDTH_ADDR, 16, address width; matches the memory address port.
WIDTH, 8, data width.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
r0_req  input  1  requester 0 access request; held until r0_ack.
r0_we  input  1  requester 0 access type: 1 = write, 0 = read.
r0_addr  input  WIDTH_ADDR  requester 0 address.
r0_wdata  input  WIDTH  requester 0 write data.
r0_ack  output  1  one-cycle pulse: requester 0 access complete.
r1_req, r1_we, r1_addr, r1_wdata, r1_ack  same as the r0 group, for requester 1.
rdata  output  WIDTH  read data; valid in the ack cycle, held until the next read completes.
grant  output  1  index of the requester currently or last served.
busy  output  1  high while state is not IDLE.
mem_addr  output  WIDTH_ADDR  to memory address input.
mem_bus_dir  output  1  to memory bus_dir: 0 = write into memory, 1 = read.
mem_load_main  output  1  to memory load_main; active-high write strobe.
mem_assert_main  output  1  to memory assert_main; active-low, so 0 enables memory onto main bus.
mem_wdata  output  WIDTH  to memory main_in.
mem_rdata  input  WIDTH  from memory main_out; combinational read of mem_addr.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; r0_ack = r1_ack = 0; rdata = 0; grant = 1 (so requester 0 wins the first contest); busy = 0.
  - mem_addr = 0, mem_wdata = 0, mem_bus_dir = 1, mem_load_main = 0, mem_assert_main = 1.
- States: IDLE -> ACCESS -> DONE -> IDLE. Encoding is defined in the package.
- IDLE:
  - Memory outputs are at their reset/inactive values.
  - If any req is high at the clock edge: pick the winner, register its addr/we/wdata into mem_addr/mem_wdata and an internal we flag, set grant, go to ACCESS.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to the current grant wins (round-robin).
  - grant updates only on a new grant.
- ACCESS (exactly one cycle):
  - Write: mem_bus_dir = 0, mem_load_main = 1, mem_assert_main = 1. Memory captures mem_wdata at the closing edge.
  - Read: mem_bus_dir = 1, mem_load_main = 0, mem_assert_main = 0. rdata <= mem_rdata at the closing edge.
  - Then go to DONE.
- DONE (one cycle):
  - Granted requester's ack = 1.
  - Memory outputs return to inactive values; mem_addr and mem_wdata hold their last values.
  - Requests are ignored in this cycle. The acked requester may still show req high here; this is not a new request.
  - Next state is IDLE.
- Latency and throughput:
  - Request first seen at edge k: ACCESS in cycle k+1, ack and rdata valid in cycle k+2.
  - One access per 3 cycles.
  - Worst-case wait under contention is 6 cycles.
- Requester contract:
  - addr/we/wdata are held stable while req is high.
  - req deasserts, or is re-asserted for a new access, no earlier than the cycle after ack.
  - Dropping req before ack is a protocol violation. The arbiter still completes an already-granted access.
- Both acks are never high in the same cycle.
- A write never changes rdata.
- Reset asserted during ACCESS:
  - mem_load_main falls immediately. A write is suppressed if reset is asserted before the closing edge.
  - No ack is produced. Requesters restart.
- Address has no wrap handling; it is passed through unchanged across the full WIDTH_ADDR range, including 0xFFFF.

Decomposition:
- Package mem_arb_pkg holds:
  - state type with IDLE/ACCESS/DONE;
  - requester index constants REQ_CPU = 0, REQ_DMA = 1;
  - inactive-level constants for the memory strobes (DIR_READ = 1, ASSERT_OFF = 1).
- No sub-module. The round-robin pick is a small function in the package.

Test Plan:
1. r0 write addr 0x1234 data 0xA5, then r0 read 0x1234:
   - mem_load_main = 1 only in the ACCESS cycle;
   - r0_ack two cycles after each request;
   - rdata = 0xA5 on the read ack.
2. r0 and r1 both request from reset (r0 read 0x0010, r1 write 0x0020 data 0x3C):
   - r0 served first, r1 acked 3 cycles later;
   - grant sequence 0, 1.
3. Both requesters continuously re-request for 12 accesses:
   - grants alternate 0,1,0,1,...;
   - no ack gap exceeds 6 cycles;
   - acks never overlap.
4. Boundary addresses: r1 write 0xFFFF data 0xFF, write 0x0000 data 0x01, read both:
   - reads return 0xFF and 0x01;
   - mem_addr matches exactly (no wrap or alias).
5. Reset asserted mid-ACCESS of a write to 0x0040 data 0x77:
   - mem_load_main drops in the same cycle;
   - no ack;
   - a later read of 0x0040 returns the prior value 0x00.
6. A held req is not double-counted:
   - r0 keeps req high through DONE, then deasserts;
   - exactly one ack; the arbiter returns to IDLE and busy = 0.
